// File: rtl/trans_sid_alloc.sv
// Transfer-ID allocator for the MCHAN control unit: round-robin SID grant,
// completion tracking from the synch unit and software clear of SIDs.

module trans_sid_alloc_chk #(
  parameter int NB = 4,
  parameter int SW = 2,
  parameter int CW = 3
) (
  input logic          clk_i,
  input logic          rst_ni,
  input logic [NB-1:0] alloc_q,
  input logic [CW-1:0] nb_alloc_q,
  input logic          gnt,
  input logic [SW-1:0] sid
);

  // Counter must track the allocation vector; a grant must target a free SID.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (32'(nb_alloc_q) == 32'($countones(alloc_q)))
        else $error("nb_alloc_q out of sync with alloc_q");
      assert (!(gnt && alloc_q[sid]))
        else $error("grant issued for an allocated SID");
    end
  end

endmodule

module trans_sid_alloc #(
  parameter int NB_TRANSFERS    = 4,
  parameter int TRANS_SID_WIDTH = $clog2(NB_TRANSFERS),
  parameter int CNT_WIDTH       = $clog2(NB_TRANSFERS + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       alloc_req_i,
  output logic                       alloc_gnt_o,
  output logic [TRANS_SID_WIDTH-1:0] alloc_sid_o,
  input  logic                       done_valid_i,
  input  logic [TRANS_SID_WIDTH-1:0] done_sid_i,
  input  logic [NB_TRANSFERS-1:0]    clr_i,
  output logic [NB_TRANSFERS-1:0]    status_o,
  output logic [NB_TRANSFERS-1:0]    done_o,
  output logic [CNT_WIDTH-1:0]       nb_alloc_o,
  output logic                       full_o,
  output logic                       busy_o
);

  localparam int NB = NB_TRANSFERS;
  localparam int SW = TRANS_SID_WIDTH;
  localparam int CW = CNT_WIDTH;

  logic [NB-1:0] r_alloc;
  logic [NB-1:0] r_done;
  logic [CW-1:0] r_nb_alloc;
  logic [SW-1:0] r_rr_ptr;
  logic          r_full;
  logic          r_busy;

  logic [NB-1:0] w_free;
  logic [SW:0]   w_pick;
  logic          w_gnt;
  logic [SW-1:0] w_sid;
  logic [NB-1:0] w_grant_oh;
  logic [NB-1:0] w_done_hit;
  logic [NB-1:0] w_alloc_d;
  logic [NB-1:0] w_done_d;
  logic [CW-1:0] w_nb_alloc_d;
  logic [SW-1:0] w_rr_ptr_d;

  // Scan from ptr upward with wrap; the lowest offset that is free wins, so
  // iterating offsets downward lets the last hit be the answer. Returns {found, sid}.
  function automatic logic [SW:0] rr_pick(input logic [NB-1:0] free, input logic [SW-1:0] ptr);
    logic          found;
    logic [SW-1:0] sid;
    logic [31:0]   idx;
    found = 1'b0;
    sid   = {SW{1'b0}};
    for (int k = NB - 1; k >= 0; k--) begin
      idx   = (32'(ptr) + 32'(k)) % 32'(NB);
      sid   = free[SW'(idx)] ? SW'(idx) : sid;
      found = found | free[SW'(idx)];
    end
    return {found, sid};
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NB-1:0] v);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < NB; i++) begin
      cnt = cnt + CW'(v[i]);
    end
    return cnt;
  endfunction

  assign w_free = ~r_alloc;
  assign w_pick = rr_pick(w_free, r_rr_ptr);
  assign w_gnt  = alloc_req_i & w_pick[SW];
  assign w_sid  = w_pick[SW-1:0];

  // One-hot views of the grant and of a completion that hits an allocated SID.
  always_comb begin
    w_grant_oh = {NB{1'b0}};
    w_done_hit = {NB{1'b0}};
    if (w_gnt) begin
      w_grant_oh[w_sid] = 1'b1;
    end else begin
      w_grant_oh = {NB{1'b0}};
    end
    if (done_valid_i) begin
      w_done_hit[done_sid_i] = r_alloc[done_sid_i];
    end else begin
      w_done_hit = {NB{1'b0}};
    end
  end

  // Clear beats a same-cycle completion; a fresh grant starts not-done.
  always_comb begin
    w_alloc_d    = (r_alloc & ~clr_i) | w_grant_oh;
    w_done_d     = (r_done | w_done_hit) & ~clr_i & ~w_grant_oh;
    w_nb_alloc_d = r_nb_alloc + CW'(w_gnt) - popcount(clr_i & r_alloc);
    w_rr_ptr_d   = r_rr_ptr;
    if (w_gnt) begin
      w_rr_ptr_d = (w_sid == SW'(NB - 1)) ? {SW{1'b0}} : w_sid + SW'(1);
    end else begin
      w_rr_ptr_d = r_rr_ptr;
    end
  end

  // Allocation state, counter, pointer and derived flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alloc    <= {NB{1'b0}};
      r_done     <= {NB{1'b0}};
      r_nb_alloc <= {CW{1'b0}};
      r_rr_ptr   <= {SW{1'b0}};
      r_full     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_alloc    <= w_alloc_d;
      r_done     <= w_done_d;
      r_nb_alloc <= w_nb_alloc_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_full     <= &w_alloc_d;
      r_busy     <= |(w_alloc_d & ~w_done_d);
    end
  end

  assign alloc_gnt_o = w_gnt;
  assign alloc_sid_o = w_sid;
  assign status_o    = r_alloc;
  assign done_o      = r_done;
  assign nb_alloc_o  = r_nb_alloc;
  assign full_o      = r_full;
  assign busy_o      = r_busy;

  trans_sid_alloc_chk #(
    .NB (NB),
    .SW (SW),
    .CW (CW)
  ) u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .alloc_q    (r_alloc),
    .nb_alloc_q (r_nb_alloc),
    .gnt        (w_gnt),
    .sid        (w_sid)
  );

endmodule

// File: tb/tb_trans_sid_alloc.sv
// Directed + short random bench for trans_sid_alloc (NB_TRANSFERS=4) with a
// queue-based scoreboard fed by a behavioural reference model.

module tb_trans_sid_alloc;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       alloc_req_i;
  logic       alloc_gnt_o;
  logic [1:0] alloc_sid_o;
  logic       done_valid_i;
  logic [1:0] done_sid_i;
  logic [3:0] clr_i;
  logic [3:0] status_o;
  logic [3:0] done_o;
  logic [2:0] nb_alloc_o;
  logic       full_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  logic [3:0] m_alloc;
  logic [3:0] m_done;
  int         m_rr;
  int         m_nb;

  trans_sid_alloc #(.NB_TRANSFERS(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .alloc_req_i  (alloc_req_i),
    .alloc_gnt_o  (alloc_gnt_o),
    .alloc_sid_o  (alloc_sid_o),
    .done_valid_i (done_valid_i),
    .done_sid_i   (done_sid_i),
    .clr_i        (clr_i),
    .status_o     (status_o),
    .done_o       (done_o),
    .nb_alloc_o   (nb_alloc_o),
    .full_o       (full_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic model_reset();
    m_alloc = 4'h0;
    m_done  = 4'h0;
    m_rr    = 0;
    m_nb    = 0;
  endtask

  // One clock of stimulus: expectations are queued at drive time, compared as outputs appear.
  task automatic cyc(input logic req, input logic dv, input logic [1:0] dsid,
                     input logic [3:0] clr, output logic [1:0] gsid);
    logic       eg;
    logic [1:0] es;
    int         idx;
    @(negedge clk_i);
    alloc_req_i  = req;
    done_valid_i = dv;
    done_sid_i   = dsid;
    clr_i        = clr;
    eg = 1'b0;
    es = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = (m_rr + k) % 4;
      if (!m_alloc[idx]) begin
        eg = 1'b1;
        es = 2'(idx);
      end
    end
    push("gnt", 32'(eg & req));
    push("sid", 32'(es));
    eg = eg & req;
    if (dv && m_alloc[dsid]) m_done[dsid] = 1'b1;
    m_nb    = m_nb - $countones(clr & m_alloc);
    m_alloc = m_alloc & ~clr;
    m_done  = m_done & ~clr;
    if (eg) begin
      m_alloc[es] = 1'b1;
      m_done[es]  = 1'b0;
      m_rr        = (int'(es) + 1) % 4;
      m_nb        = m_nb + 1;
    end
    push("status", 32'(m_alloc));
    push("done", 32'(m_done));
    push("nb_alloc", 32'(m_nb));
    push("full", 32'(&m_alloc));
    push("busy", 32'(|(m_alloc & ~m_done)));
    #1;
    pop_chk(32'(alloc_gnt_o));
    pop_chk(32'(alloc_sid_o));
    gsid = alloc_sid_o;
    @(posedge clk_i);
    #1;
    alloc_req_i  = 1'b0;
    done_valid_i = 1'b0;
    done_sid_i   = 2'd0;
    clr_i        = 4'h0;
    pop_chk(32'(status_o));
    pop_chk(32'(done_o));
    pop_chk(32'(nb_alloc_o));
    pop_chk(32'(full_o));
    pop_chk(32'(busy_o));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_status"}, 32'(status_o), 32'h0);
    chk({tag, "_done"}, 32'(done_o), 32'h0);
    chk({tag, "_nb"}, 32'(nb_alloc_o), 32'h0);
    chk({tag, "_full"}, 32'(full_o), 32'h0);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_gnt"}, 32'(alloc_gnt_o), 32'h0);
  endtask

  initial begin
    logic [1:0] s;
    rst_ni       = 1'b0;
    alloc_req_i  = 1'b0;
    done_valid_i = 1'b0;
    done_sid_i   = 2'd0;
    clr_i        = 4'h0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill all four SIDs in order, then a request while full.
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t1_sid0", 32'(s), 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t1_sid1", 32'(s), 32'd1);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t1_sid2", 32'(s), 32'd2);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t1_sid3", 32'(s), 32'd3);
    chk("t1_full", 32'(full_o), 32'd1);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s);

    // Free SID 2 while full and reuse it.
    cyc(1'b0, 1'b0, 2'd0, 4'b0100, s); chk("t2_nb3", 32'(nb_alloc_o), 32'd3);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s);    chk("t2_sid2", 32'(s), 32'd2);
    chk("t2_nb4", 32'(nb_alloc_o), 32'd4);

    // Round-robin skips the just-freed SID 0, then wraps back to it.
    cyc(1'b0, 1'b0, 2'd0, 4'hF, s);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t3_sid3", 32'(s), 32'd3);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t3_sid0", 32'(s), 32'd0);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t3_sid1", 32'(s), 32'd1);
    cyc(1'b0, 1'b0, 2'd0, 4'b0001, s);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t3_rr_sid2", 32'(s), 32'd2);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t3_wrap_sid0", 32'(s), 32'd0);
    cyc(1'b0, 1'b0, 2'd0, 4'hF, s);

    // Completion on an allocated SID, then on a free SID.
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t4_sid1", 32'(s), 32'd1);
    cyc(1'b0, 1'b1, 2'd1, 4'h0, s);
    chk("t4_done", 32'(done_o), 32'b0010);
    chk("t4_busy", 32'(busy_o), 32'd0);
    cyc(1'b0, 1'b1, 2'd3, 4'h0, s);
    chk("t4_ign_done", 32'(done_o), 32'b0010);
    chk("t4_ign_status", 32'(status_o), 32'b0010);
    cyc(1'b0, 1'b0, 2'd0, 4'hF, s);

    // Grant, done and clear together; then done+clear on one SID plus clear of a free SID.
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t5_pre_sid2", 32'(s), 32'd2);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s);
    cyc(1'b0, 1'b0, 2'd0, 4'b1100, s);
    cyc(1'b1, 1'b1, 2'd1, 4'b0001, s); chk("t5_sid2", 32'(s), 32'd2);
    chk("t5_status", 32'(status_o), 32'b0110);
    chk("t5_done", 32'(done_o), 32'b0010);
    cyc(1'b0, 1'b1, 2'd2, 4'b1100, s);
    chk("t5_clr_wins", 32'(done_o[2]), 32'd0);
    chk("t5_nb1", 32'(nb_alloc_o), 32'd1);

    // Asynchronous reset with three SIDs allocated.
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s);
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s);
    chk("t6_nb3", 32'(nb_alloc_o), 32'd3);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all_zero("t6_async");
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cyc(1'b1, 1'b0, 2'd0, 4'h0, s); chk("t6_first_sid0", 32'(s), 32'd0);

    // Short random mix against the reference model.
    for (int n = 0; n < 60; n++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0, s);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
